// File: rtl/matmul_seq_ctrl.sv
// Command-stream sequencer for the matrix-multiply engine: loads A/B from the UART byte
// stream, steps the MAC through every C[i][j] and streams each result out MSB first.
module matmul_seq_ctrl #(
  parameter int MAX_N     = 4,
  parameter int ADDR_W    = 4,
  parameter int ACC_W     = 24,
  parameter int RES_BYTES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              buf_we,
  output logic              buf_sel,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              mac_clr,
  output logic              mac_en,
  input  logic [ACC_W-1:0]  acc_in,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err,
  output logic              done
);

  localparam int CW = ADDR_W / 2;
  localparam int BW = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
  localparam int RW = RES_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_CLR, S_MAC, S_DRAIN, S_SEND, S_WAIT_TX
  } state_t;

  state_t            state_q, state_d;
  logic [CW:0]       n_q, n_d;
  logic [CW-1:0]     row_q, row_d, col_q, col_d, k_q, k_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic              drain_q, drain_d;
  logic              first_q, first_d;
  logic [RW-1:0]     res_q, res_d;
  logic              buf_we_q, buf_we_d, buf_sel_q, buf_sel_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              mac_en_q, mac_en_d, err_q, err_d, done_q, done_d;

  logic [CW:0] n_last;
  logic        last_col, last_row, last_k, size_ok;

  assign n_last   = n_q - (CW+1)'(1);
  assign last_col = ({1'b0, col_q} == n_last);
  assign last_row = ({1'b0, row_q} == n_last);
  assign last_k   = ({1'b0, k_q} == n_last);
  assign size_ok  = (rx_data != 8'd0) && (rx_data <= 8'(MAX_N));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      byte_q   <= '0;
      drain_q  <= 1'b0;
      first_q  <= 1'b0;
      res_q    <= '0;
      buf_we_q <= 1'b0;
      buf_sel_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      mac_en_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      row_q    <= row_d;
      col_q    <= col_d;
      k_q      <= k_d;
      byte_q   <= byte_d;
      drain_q  <= drain_d;
      first_q  <= first_d;
      res_q    <= res_d;
      buf_we_q <= buf_we_d;
      buf_sel_q <= buf_sel_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      mac_en_q <= mac_en_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    byte_d    = byte_q;
    drain_d   = drain_q;
    first_d   = first_q;
    res_d     = res_q;
    buf_we_d  = 1'b0;
    buf_sel_d = buf_sel_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    mac_en_d  = 1'b0;
    err_d     = 1'b0;
    done_d    = 1'b0;
    mac_clr   = 1'b0;
    tx_start  = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (size_ok) begin
            n_d     = rx_data[CW:0];
            row_d   = '0;
            col_d   = '0;
            state_d = S_LOAD_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        if (rx_valid) begin
          buf_we_d  = 1'b1;
          buf_sel_d = (state_q == S_LOAD_B);
          waddr_d   = {row_q, col_q};
          wdata_d   = rx_data;
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_CLR;
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_CLR: begin
        mac_clr = 1'b1;
        k_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        rd_addr_a = {row_q, k_q};
        rd_addr_b = {k_q, col_q};
        mac_en_d  = 1'b1;
        if (last_k) begin
          k_d     = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      S_DRAIN: begin
        // First cycle lets the final mac_en land in the accumulator.
        if (!drain_q) begin
          drain_d = 1'b1;
        end else begin
          res_d   = RW'(acc_in);
          byte_d  = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          first_d  = 1'b1;
          state_d  = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        // The transmitter may not raise busy until the cycle after tx_start.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!tx_busy) begin
          if (byte_q != BW'(RES_BYTES - 1)) begin
            byte_d  = byte_q + BW'(1);
            state_d = S_SEND;
          end else if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              row_d   = row_q + CW'(1);
              state_d = S_CLR;
            end
          end else begin
            col_d   = col_q + CW'(1);
            state_d = S_CLR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_data   = 8'(res_q >> (8 * (RES_BYTES - 1 - int'(byte_q))));
  assign buf_we    = buf_we_q;
  assign buf_sel   = buf_sel_q;
  assign buf_waddr = waddr_q;
  assign buf_wdata = wdata_q;
  assign mac_en    = mac_en_q;
  assign err       = err_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer between the UART byte stream and the matrix-multiply datapath.
- Parses the command stream: size byte N, then N*N bytes of A, then N*N bytes of B, all row-major. Writes A and B into external operand buffers, steps the MAC datapath through every C[i][j], and streams each result to the UART transmitter as big-endian bytes.
- Sits between uart_rx/uart_tx and the operand buffers + MAC unit inside top.

Parameters:
- MAX_N, 4, largest accepted matrix dimension; must be a power of two.
- ADDR_W, 4, buffer address width, = 2*log2(MAX_N).
- ACC_W, 24, accumulator width from the MAC.
- RES_BYTES, 3, bytes sent per result element, = ACC_W/8.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  one-cycle pulse, rx_data holds a received byte
- rx_data  in  8  received byte
- buf_we  out  1  operand buffer write enable
- buf_sel  out  1  0 = buffer A, 1 = buffer B
- buf_waddr  out  ADDR_W  write address
- buf_wdata  out  8  write data
- rd_addr_a  out  ADDR_W  A read address; synchronous read, data one cycle later
- rd_addr_b  out  ADDR_W  B read address; same timing
- mac_clr  out  1  clear accumulator
- mac_en  out  1  acc <= acc + a*b (aligned with read data)
- acc_in  in  ACC_W  accumulator value
- tx_start  out  1  one-cycle request to send tx_data
- tx_data  out  8  byte to transmit
- tx_busy  in  1  transmitter busy
- busy  out  1  high whenever not IDLE
- err  out  1  one-cycle pulse on an illegal size byte
- done  out  1  one-cycle pulse after the last result byte completes

Behaviour:
- Reset: state IDLE. All outputs 0; row/col/k counters 0; stored N = 0. Reset in any state aborts the operation immediately. Partial buffer contents are don't-care.
- Address map: addr = row*MAX_N + col, for both writes and reads. Independent of N.
- IDLE: on rx_valid, if 1 <= rx_data <= MAX_N: latch N, go to LOAD_A. Otherwise pulse err on the next cycle and stay in IDLE.
- LOAD_A / LOAD_B: each rx_valid produces, the next cycle, buf_we=1 for one cycle with buf_sel, buf_waddr, buf_wdata=rx_data. col increments; when col reaches N-1 it wraps to 0 and row increments. After element (N-1,N-1): A goes to LOAD_B; B goes to CLR with row = col = 0.
- CLR: mac_clr=1 for one cycle, k=0, go to MAC.
- MAC: issue exactly N reads, one per cycle:
  - rd_addr_a = i*MAX_N + k, rd_addr_b = k*MAX_N + j.
  - mac_en is asserted the cycle after each read, so it is high for N cycles, lagging the reads by one.
  - After the last read, go to DRAIN.
- DRAIN: wait until the cycle after the last mac_en, then latch acc_in into a result register. Go to SEND, byte index 0.
- SEND: when tx_busy = 0, pulse tx_start with tx_data = result byte, MSB first; go to WAIT_TX.
- WAIT_TX: ignore tx_busy for the first cycle after tx_start, then wait for tx_busy = 0.
  - If more bytes remain: back to SEND.
  - Else advance j, then i (same wrap rule as loading) and go to CLR.
  - After C[N-1][N-1]: pulse done and return to IDLE.
- rx_valid outside IDLE/LOAD_A/LOAD_B is ignored; no buffer write, no state change.
- rx_valid on the same cycle as the final buf_we is accepted; write pipelining allows one byte per cycle.
- Results wider than the acc_in value are zero-extended; there is no saturation. MAX_N*255*255 < 2^ACC_W.
- tx_start never asserts while tx_busy = 1; at most one tx_start per byte.
- Latency per element: 1 (CLR) + N (MAC) + 2 (DRAIN) cycles before the first tx_start.

Test Plan:
- N=2, A=01 02 03 04, B=05 06 07 08 -> tx bytes 00 00 13 00 00 16 00 00 2B 00 00 32, then done pulse, busy=0.
- N=3, A=01 02 03 04 03 04 04 03 04, B=05 06 07 08 07 08 08 07 08 -> C = 45,41,47,76,73,84,76,73,84 (decimal), 27 bytes MSB first, then done.
- Size bytes 00 and 05 (MAX_N=4) -> err pulse each, state stays IDLE, no buf_we; a following 02 is accepted normally.
- N=4, all A and B = FF -> 16 results of 03 F8 04 each; tx_busy held high 100 cycles after each start -> no tx_start while busy, no bytes lost or duplicated.
- rst asserted after 3 A bytes, then full N=2 stream -> outputs 0 the cycle after rst; the N=2 case completes with correct results.
- rx_valid pulses injected during MAC/SEND -> no buf_we, results unchanged.
